// File: rtl/spi_stream_pkg.sv
// Shared types and helpers for the streaming serial transmitter.
package spi_stream_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        HIGH  = 2'd2
    } state_t;

    // Width of a counter that indexes the bits of an n-bit word.
    function automatic int bit_cnt_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/spi_phase_timer.sv
// Half-period phase counter: latches the half period on load and ticks on its last cycle.
module spi_phase_timer #(
    parameter int DIV_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic                 run,
    input  logic [DIV_WIDTH-1:0] half_in,
    output logic                 tick
);

    logic [DIV_WIDTH-1:0] half_q;
    logic [DIV_WIDTH-1:0] cnt;

    assign tick = run && (cnt == half_q - 1'b1);

    // A programmed half period of zero is run as one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            half_q <= DIV_WIDTH'(1);
            cnt    <= '0;
        end else if (load) begin
            half_q <= (half_in == '0) ? DIV_WIDTH'(1) : half_in;
            cnt    <= '0;
        end else if (tick || !run) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/spi_stream_tx.sv
// Streaming serialiser: one-word holding register feeding a shifter that drives
// a data line plus a generated clock (idle low, slave samples on the rising edge).
module spi_stream_tx
    import spi_stream_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DIV_WIDTH  = 16,
    parameter bit LSB_FIRST  = 1'b0
) (
    input  logic                  spi_clk,
    input  logic                  spi_reset_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [DIV_WIDTH-1:0]  cfg_half_period,
    output logic                  spi_output_data,
    output logic                  spi_output_clock,
    output logic                  spi_busy,
    output logic                  word_done
);

    localparam int              BW       = bit_cnt_width(DATA_WIDTH);
    localparam logic [BW-1:0]   LAST_BIT = BW'(DATA_WIDTH - 1);

    state_t                  state, state_n;
    logic                    hold_full, hold_full_n;
    logic [DATA_WIDTH-1:0]   hold_data;
    logic [DATA_WIDTH-1:0]   shreg, shifted;
    logic [BW-1:0]           bit_cnt;
    logic                    tick, load, shift;
    logic                    data_n, clk_n, done_n;

    function automatic logic first_bit(input logic [DATA_WIDTH-1:0] w);
        return LSB_FIRST ? w[0] : w[DATA_WIDTH-1];
    endfunction

    assign shifted     = LSB_FIRST ? (shreg >> 1) : (shreg << 1);
    assign hold_full_n = hold_full ? !load : (in_valid && in_ready);
    assign spi_busy    = (state != IDLE) || hold_full;

    spi_phase_timer #(.DIV_WIDTH(DIV_WIDTH)) u_timer (
        .clk     (spi_clk),
        .rst_n   (spi_reset_n),
        .load    (load),
        .run     (state != IDLE),
        .half_in (cfg_half_period),
        .tick    (tick)
    );

    always_ff @(posedge spi_clk or negedge spi_reset_n) begin
        if (!spi_reset_n) state <= IDLE;
        else              state <= state_n;
    end

    always_comb begin
        state_n = state;
        load    = 1'b0;
        shift   = 1'b0;
        data_n  = spi_output_data;
        clk_n   = spi_output_clock;
        done_n  = 1'b0;
        case (state)
            IDLE: begin
                if (hold_full) begin
                    load    = 1'b1;
                    data_n  = first_bit(hold_data);
                    state_n = SETUP;
                end
            end
            SETUP: begin
                if (tick) begin
                    clk_n   = 1'b1;
                    state_n = HIGH;
                end
            end
            HIGH: begin
                if (tick) begin
                    clk_n = 1'b0;
                    if (bit_cnt != LAST_BIT) begin
                        shift   = 1'b1;
                        data_n  = first_bit(shifted);
                        state_n = SETUP;
                    end else begin
                        done_n = 1'b1;
                        // Chain straight into the held word on the same falling edge.
                        if (hold_full) begin
                            load    = 1'b1;
                            data_n  = first_bit(hold_data);
                            state_n = SETUP;
                        end else begin
                            data_n  = 1'b0;
                            state_n = IDLE;
                        end
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge spi_clk or negedge spi_reset_n) begin
        if (!spi_reset_n) begin
            hold_full        <= 1'b0;
            hold_data        <= '0;
            in_ready         <= 1'b1;
            shreg            <= '0;
            bit_cnt          <= '0;
            spi_output_data  <= 1'b0;
            spi_output_clock <= 1'b0;
            word_done        <= 1'b0;
        end else begin
            hold_full        <= hold_full_n;
            in_ready         <= !hold_full_n;
            spi_output_data  <= data_n;
            spi_output_clock <= clk_n;
            word_done        <= done_n;
            if (in_valid && in_ready) hold_data <= in_data;
            if (load) begin
                shreg   <= hold_data;
                bit_cnt <= '0;
            end else if (shift) begin
                shreg   <= shifted;
                bit_cnt <= bit_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_spi_stream_tx.sv
// Directed bench for spi_stream_tx: waveform timing, back-to-back, bit order, divider, backpressure, reset.
module tb_spi_stream_tx;

    logic        spi_clk = 1'b0;
    logic        spi_reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        lsb_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic [15:0] cfg_half_period = 16'd3;
    logic        in_ready, spi_output_data, spi_output_clock, spi_busy, word_done;
    logic        lsb_ready, lsb_data, lsb_clock, lsb_busy, lsb_done;

    int          vectors = 0;
    int          miscompares = 0;
    int          rises = 0;
    int          dones = 0;
    logic [63:0] rx = '0;
    logic        clk_prev = 1'b0;

    always #5 spi_clk = ~spi_clk;

    spi_stream_tx #(.DATA_WIDTH(8), .DIV_WIDTH(16), .LSB_FIRST(1'b0)) dut (
        .spi_clk          (spi_clk),
        .spi_reset_n      (spi_reset_n),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_data          (in_data),
        .cfg_half_period  (cfg_half_period),
        .spi_output_data  (spi_output_data),
        .spi_output_clock (spi_output_clock),
        .spi_busy         (spi_busy),
        .word_done        (word_done)
    );

    spi_stream_tx #(.DATA_WIDTH(8), .DIV_WIDTH(16), .LSB_FIRST(1'b1)) dut_lsb (
        .spi_clk          (spi_clk),
        .spi_reset_n      (spi_reset_n),
        .in_valid         (lsb_valid),
        .in_ready         (lsb_ready),
        .in_data          (in_data),
        .cfg_half_period  (cfg_half_period),
        .spi_output_data  (lsb_data),
        .spi_output_clock (lsb_clock),
        .spi_busy         (lsb_busy),
        .word_done        (lsb_done)
    );

    // Slave model: captures data on each rising serial clock, counts done pulses.
    initial forever begin
        @(negedge spi_clk);
        if (spi_output_clock && !clk_prev) begin
            rises = rises + 1;
            rx    = {rx[62:0], spi_output_data};
        end
        clk_prev = spi_output_clock;
        if (word_done) dones = dones + 1;
    end

    task automatic tick();
        @(negedge spi_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors = vectors + 1;
        assert (obs === exp) else begin
            miscompares = miscompares + 1;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Walks one 8-bit word cycle by cycle from phase index k0; leaves us on the cycle after the last fall.
    task automatic check_word(input string tag, input logic [7:0] w, input int h, input int k0, input bit lsb);
        logic [7:0] ww;
        ww = w;
        for (int k = k0; k < 16 * h; k++) begin
            int b;
            b = k / (2 * h);
            chk({tag, "_data"}, lsb ? lsb_data : spi_output_data, lsb ? ww[b] : ww[7 - b]);
            chk({tag, "_clk"}, lsb ? lsb_clock : spi_output_clock, 32'((k % (2 * h)) >= h));
            tick();
        end
    endtask

    initial begin
        // Reset state
        tick();
        chk("rst_ready", in_ready, 1);
        chk("rst_busy", spi_busy, 0);
        chk("rst_data", spi_output_data, 0);
        chk("rst_clk", spi_output_clock, 0);
        chk("rst_done", word_done, 0);
        spi_reset_n = 1'b1;
        tick();

        // Single word 0xA5, half period 3
        rises = 0; dones = 0;
        in_valid = 1'b1; in_data = 8'hA5;
        tick();
        in_valid = 1'b0;
        chk("a5_held_ready", in_ready, 0);
        chk("a5_held_busy", spi_busy, 1);
        chk("a5_held_data", spi_output_data, 0);
        tick();
        check_word("a5", 8'hA5, 3, 0, 1'b0);
        chk("a5_end_data", spi_output_data, 0);
        chk("a5_done", word_done, 1);
        chk("a5_idle_busy", spi_busy, 0);
        chk("a5_ready", in_ready, 1);
        chk("a5_rises", rises, 8);
        chk("a5_dones", dones, 1);
        tick();
        chk("a5_done_pulse", word_done, 0);

        // Back-to-back 0xFF then 0x00 with valid held high
        rises = 0; dones = 0;
        in_valid = 1'b1; in_data = 8'hFF;
        tick();
        in_data = 8'h00;
        chk("b2b_ready_lo", in_ready, 0);
        tick();
        chk("b2b_ready_hi", in_ready, 1);
        chk("b2b_first", spi_output_data, 1);
        tick();
        in_valid = 1'b0;
        chk("b2b_ready_lo2", in_ready, 0);
        check_word("b2b_ff", 8'hFF, 3, 1, 1'b0);
        chk("b2b_done1", word_done, 1);
        chk("b2b_busy_mid", spi_busy, 1);
        check_word("b2b_00", 8'h00, 3, 0, 1'b0);
        chk("b2b_done2", word_done, 1);
        chk("b2b_busy_end", spi_busy, 0);
        chk("b2b_rises", rises, 16);
        chk("b2b_dones", dones, 2);

        // LSB-first instance, 0x01
        tick();
        lsb_valid = 1'b1; in_data = 8'h01;
        tick();
        lsb_valid = 1'b0;
        tick();
        check_word("lsb", 8'h01, 3, 0, 1'b1);
        chk("lsb_done", lsb_done, 1);
        chk("lsb_end_data", lsb_data, 0);
        chk("lsb_busy", lsb_busy, 0);

        // Half period 0 runs as 1
        tick();
        cfg_half_period = 16'd0;
        in_valid = 1'b1; in_data = 8'hC3;
        tick();
        in_valid = 1'b0;
        tick();
        check_word("div0", 8'hC3, 1, 0, 1'b0);
        chk("div0_done", word_done, 1);
        chk("div0_busy", spi_busy, 0);

        // Half period change mid-word applies to the next word only
        tick();
        cfg_half_period = 16'd3;
        in_valid = 1'b1; in_data = 8'h81;
        tick();
        in_data = 8'h7E;
        tick();
        tick();
        in_valid = 1'b0;
        cfg_half_period = 16'd5;
        check_word("cfg3", 8'h81, 3, 1, 1'b0);
        chk("cfg3_done", word_done, 1);
        check_word("cfg5", 8'h7E, 5, 0, 1'b0);
        chk("cfg5_done", word_done, 1);
        chk("cfg5_busy", spi_busy, 0);

        // Backpressure: third word waits for the second to load; junk ignored meanwhile
        tick();
        cfg_half_period = 16'd1;
        rises = 0;
        in_valid = 1'b1; in_data = 8'h11;
        tick();
        in_data = 8'h22;
        tick();
        tick();
        for (int k = 1; k < 16; k++) begin
            in_data = k[0] ? 8'hEE : 8'h99;
            chk("bp_ready_lo", in_ready, 0);
            tick();
        end
        chk("bp_ready_hi", in_ready, 1);
        in_data = 8'h33;
        tick();
        in_valid = 1'b0;
        chk("bp_ready_lo3", in_ready, 0);
        for (int i = 0; i < 200 && spi_busy; i++) tick();
        chk("bp_idle", spi_busy, 0);
        chk("bp_rises", rises, 24);
        chk("bp_bits", rx[23:0], 24'h112233);

        // Asynchronous reset after the 3rd rising edge, with a word held
        tick();
        cfg_half_period = 16'd2;
        rises = 0;
        in_valid = 1'b1; in_data = 8'hF0;
        tick();
        in_data = 8'h0F;
        tick();
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 100 && rises < 3; i++) tick();
        chk("ar_rises", rises, 3);
        chk("ar_pre_clk", spi_output_clock, 1);
        spi_reset_n = 1'b0;
        #1;
        chk("ar_data", spi_output_data, 0);
        chk("ar_clk", spi_output_clock, 0);
        chk("ar_done", word_done, 0);
        chk("ar_ready", in_ready, 1);
        chk("ar_busy", spi_busy, 0);
        tick();
        tick();
        spi_reset_n = 1'b1;
        tick();
        rises = 0;
        chk("ar_rel_ready", in_ready, 1);
        chk("ar_rel_busy", spi_busy, 0);
        for (int i = 0; i < 40; i++) tick();
        chk("ar_no_rises", rises, 0);
        chk("ar_quiet_data", spi_output_data, 0);
        chk("ar_quiet_busy", spi_busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/spi_stream_tx.md
# spi_stream_tx

Parametrised streaming serialiser for the LED-strip data/clock interface: accepts words over a valid/ready handshake and shifts them out as a data line plus a generated clock. The next-generation byte writer, adding:
- configurable word width and bit order;
- a runtime-programmable clock half-period;
- a one-entry holding register, so consecutive words go out with no idle gap.

It sits between the pixel/frame sequencer and the strip output pins.

## Interface
- DATA_WIDTH, 8, bits per word; legal range ≥2.
- DIV_WIDTH, 16, width of the half-period configuration input.
- LSB_FIRST, 0, 0 = MSB shifted first, 1 = LSB shifted first.

Ports:
- spi_clk  in  1  single clock; all logic on rising edge.
- spi_reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  word offered.
- in_ready  out  1  holding register empty; transfer on in_valid && in_ready.
- in_data  in  DATA_WIDTH  word to send.
- cfg_half_period  in  DIV_WIDTH  cycles per clock phase; sampled when a word is loaded into the shifter.
- spi_output_data  out  1  serial data.
- spi_output_clock  out  1  serial clock; idles low; slave samples on rising edge.
- spi_busy  out  1  high while a word is held or being shifted.
- word_done  out  1  one-cycle pulse per completed word.

## Operation
- Reset (async assert, sync release):
  - state IDLE; hold register empty; shifter, bit and phase counters cleared.
  - spi_output_data, spi_output_clock, word_done = 0; in_ready = 1; spi_busy = 0.
  - A word in flight is abandoned and the held word discarded.
- Holding register: loaded on handshake. in_ready = !hold_full, registered. While in_ready is low, in_data is ignored.
- States:
  - IDLE:
    - If hold_full: move the held word to the shifter and clear hold_full.
    - Latch half = max(cfg_half_period, 1); a value of 0 is treated as 1.
    - Drive the first bit (MSB, or LSB if LSB_FIRST); go to SETUP with the phase counter at 0.
  - SETUP: clock low, data stable.
    - Counter counts 0..half-1.
    - At half-1: spi_output_clock <= 1, go to HIGH, counter 0.
  - HIGH: clock high.
    - At counter half-1: spi_output_clock <= 0, then one of:
      - (a) bits remain: shift, drive next bit, go to SETUP.
      - (b) last bit and hold_full: load the next word (re-latch half), drive its first bit, go to SETUP; word_done pulses.
      - (c) last bit and hold empty: spi_output_data <= 0, go to IDLE; word_done pulses.
- spi_busy = (state != IDLE) || hold_full.
- Bit counter: $clog2(DATA_WIDTH) bits. Phase counter: DIV_WIDTH bits; it never exceeds half-1.
- cfg_half_period changes mid-word take effect only at the next word load.

## Timing
- Handshake at edge t → hold_full at t+1 → first bit on spi_output_data after edge t+2 when starting from IDLE.
- Per bit: data is stable for `half` cycles with the clock low, then `half` cycles with the clock high. Bit period is 2·half cycles; word period is DATA_WIDTH·2·half cycles.
- Data changes only on the same edge as a clock fall, or on a load from IDLE, so the slave sees hold time = 0 cycles after the fall and setup = half cycles.
- Back-to-back: if the hold register is filled before the final HIGH phase ends, the next word's first bit follows the last falling edge on the same edge, with no gap.
- A word accepted during case (c)'s transition cycle starts from IDLE one cycle later.
- word_done is high for exactly the cycle following the final clock fall.

## Structure
- Package spi_stream_pkg: state enum (IDLE, SETUP, HIGH) and a function for the bit-counter width.
- Sub-module spi_phase_timer: load/terminal-count counter producing the half-period tick. It is instantiated once; the FSM, shifter and hold register stay in the top.

## Test plan
- DATA_WIDTH=8, cfg=3, send 0xA5 → data bits 1,0,1,0,0,1,0,1, each held 6 cycles; clock high in cycles 3–5 of each bit; 8 rising edges; word_done once; back to IDLE with data=0.
- 0xFF then 0x00 with in_valid held high → second word accepted one cycle after the first load; 96 contiguous cycles, 16 rising edges, no idle between words; two word_done pulses.
- LSB_FIRST=1, send 0x01 → first bit 1, remaining seven bits 0.
- cfg_half_period=0 → treated as 1: bit period 2 cycles, word 16 cycles. Change cfg from 3 to 5 mid-word → the current word stays at 3, the next word uses 5.
- Backpressure: offer three words while the first shifts → in_ready low after the second is held; the third is accepted only when the second loads; in_data toggling while in_ready is low has no effect.
- Assert spi_reset_n low after the 3rd rising edge of a word → all outputs 0 immediately (asynchronous); after release in_ready=1, spi_busy=0, and no residual bits are emitted.
